// File: rtl/pkt_fifo_unloader.sv
// Purpose : read side of the packet FIFO; issues reads, absorbs read latency in a skid buffer, frames output.
// Latency : fifo_rden in cycle n -> tx_valid in cycle n+c_RD_LATENCY+1; 1 word/clock sustained.
// Backpressure: tx_ready low holds the head word; reads stop once buffered + in-flight words fill the skid.
//
// Ports:
//   RdClock, Reset          sole clock, synchronous active-high reset
//   fifo_empty/fifo_rden    FIFO read handshake, one word per fifo_rden cycle
//   fifo_q                  {eop, sop, payload}, valid c_RD_LATENCY cycles after fifo_rden
//   tx_valid/tx_ready       output stream with tx_sop/tx_eop/tx_data from the skid head
//   pkt_count               EOP transfers delivered, wraps
//   frame_err               sticky framing error (orphan word or SOP inside a packet)
//   busy                    words in flight or buffered, or a packet is open
module pkt_fifo_unloader #(
    parameter int c_DATA_WIDTH = 64,
    parameter int c_RD_LATENCY = 2,
    parameter int c_SKID_DEPTH = 4,
    parameter int c_CNT_WIDTH  = 16
) (
    input  logic                    RdClock,
    input  logic                    Reset,
    input  logic                    fifo_empty,
    output logic                    fifo_rden,
    input  logic [c_DATA_WIDTH+1:0] fifo_q,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic                    tx_sop,
    output logic                    tx_eop,
    output logic [c_DATA_WIDTH-1:0] tx_data,
    output logic [c_CNT_WIDTH-1:0]  pkt_count,
    output logic                    frame_err,
    output logic                    busy
);

    localparam int PTR_W = $clog2(c_SKID_DEPTH);
    // Wide enough to hold occ + inflight without overflow.
    localparam int OCC_W = $clog2(c_SKID_DEPTH + c_RD_LATENCY + 1);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(c_SKID_DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PKT  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [c_RD_LATENCY-1:0]  ret_sr_q, ret_sr_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]         occ_q, occ_d;
    logic [c_CNT_WIDTH-1:0]   pkt_count_q, pkt_count_d;
    logic                     frame_err_q, frame_err_d;
    logic [c_DATA_WIDTH+1:0]  skid_q [c_SKID_DEPTH];

    logic [OCC_W-1:0]         inflight;
    logic [c_DATA_WIDTH+1:0]  head;
    logic                     head_sop;
    logic                     head_eop;
    logic                     have_head;
    logic                     drop;
    logic                     xfer;
    logic                     pop;
    logic                     push;

    // Reads still travelling through the FIFO's read pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < c_RD_LATENCY; i++) begin
            inflight = inflight + OCC_W'(ret_sr_q[i]);
        end
    end

    // Credit check: every issued read must have a guaranteed skid slot when it lands.
    assign fifo_rden = !fifo_empty && !Reset && ((occ_q + inflight) < DEPTH_C);

    // Tail of the return shift register marks the cycle fifo_q carries a requested word.
    assign push      = ret_sr_q[c_RD_LATENCY-1] && !Reset;

    assign head      = skid_q[rd_ptr_q];
    assign head_sop  = head[c_DATA_WIDTH];
    assign head_eop  = head[c_DATA_WIDTH+1];
    assign have_head = (occ_q != '0);

    // A word without SOP outside a packet is an orphan: discard it without presenting it.
    assign drop      = have_head && (state_q == S_IDLE) && !head_sop;
    assign tx_valid  = have_head && !drop;
    assign xfer      = tx_valid && tx_ready;
    assign pop       = xfer || drop;

    // Gate payload/framing with tx_valid so idle outputs read as zero.
    assign tx_sop    = tx_valid && head_sop;
    assign tx_eop    = tx_valid && head_eop;
    assign tx_data   = tx_valid ? head[c_DATA_WIDTH-1:0] : '0;

    assign pkt_count = pkt_count_q;
    assign frame_err = frame_err_q;
    assign busy      = have_head || (ret_sr_q != '0) || (state_q == S_PKT);

    always_comb begin
        state_d     = state_q;
        pkt_count_d = pkt_count_q;
        frame_err_d = frame_err_q;
        ret_sr_d    = (ret_sr_q << 1) | c_RD_LATENCY'(fifo_rden);
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        occ_d       = occ_q + OCC_W'(push) - OCC_W'(pop);

        if (drop) begin
            frame_err_d = 1'b1;
        end

        if (xfer) begin
            // SOP seen while a packet is open: flag it but keep forwarding.
            if ((state_q == S_PKT) && head_sop) begin
                frame_err_d = 1'b1;
            end
            if (head_eop) begin
                state_d     = S_IDLE;
                pkt_count_d = pkt_count_q + c_CNT_WIDTH'(1);
            end else begin
                state_d     = S_PKT;
            end
        end
    end

    always_ff @(posedge RdClock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            ret_sr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            pkt_count_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_sr_q    <= ret_sr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            pkt_count_q <= pkt_count_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Storage needs no reset: occ gates every read of it.
    always_ff @(posedge RdClock) begin
        if (push) begin
            skid_q[wr_ptr_q] <= fifo_q;
        end
    end

endmodule
